// File: rtl/ov7670_capture_sequencer.sv
// ov7670_capture_sequencer: gates camera pixel writes per frame and steers each frame into the back bank
// of a ping-pong buffer, swapping to the display only on a frame with exactly FRAME_PIXELS pixels.
module ov7670_capture_sequencer #(
   parameter int FRAME_PIXELS = 76800,
   parameter int DECIM        = 1
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        v_sync,
   input  logic        mc_we,
   input  logic [16:0] mc_wAddr,
   input  logic [15:0] mc_wData,
   input  logic        cmd_start,
   input  logic        cmd_stop,
   input  logic        mode_single,
   output logic        fb_we,
   output logic [17:0] fb_wAddr,
   output logic [15:0] fb_wData,
   output logic        disp_bank,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err,
   output logic [7:0]  frame_cnt
);
   localparam logic [16:0] FP     = 17'(FRAME_PIXELS);
   localparam logic [7:0]  SKIP_N = 8'(DECIM - 1);

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, SKIP} state_t;
   state_t state, state_n;

   logic        v_sync_d, rise, fall, wr_bank;
   logic [16:0] pix_cnt;
   logic [7:0]  skip_cnt;
   logic        mode_r, stop_pend;
   logic        accept, commit, discard;

   assign rise    = v_sync & ~v_sync_d;
   assign fall    = ~v_sync & v_sync_d;
   assign wr_bank = ~disp_bank;
   assign busy    = state != IDLE;

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      commit  = 1'b0;
      discard = 1'b0;
      case (state)
         IDLE: state_n = (cmd_start && !cmd_stop) ? ARM : IDLE;
         ARM:  state_n = cmd_stop ? IDLE : fall ? CAPTURE : ARM;
         CAPTURE: begin
            accept  = mc_we && !rise && mc_wAddr < FP && pix_cnt < FP;
            commit  = rise && pix_cnt == FP;
            discard = rise && pix_cnt != FP;
            // a stop seen on the rise cycle itself still ends the run after this frame
            if (rise)
               state_n = ((mode_r && commit) || stop_pend || cmd_stop) ? IDLE :
                         (!mode_r && DECIM > 1) ? SKIP : ARM;
         end
         SKIP:    state_n = cmd_stop ? IDLE : (rise && skip_cnt <= 8'd1) ? ARM : SKIP;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state      <= IDLE;
         v_sync_d   <= 1'b0;
         pix_cnt    <= '0;
         skip_cnt   <= '0;
         mode_r     <= 1'b0;
         stop_pend  <= 1'b0;
         fb_we      <= 1'b0;
         fb_wAddr   <= '0;
         fb_wData   <= '0;
         disp_bank  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_n;
         v_sync_d   <= v_sync;
         fb_we      <= accept;
         frame_done <= commit;
         frame_err  <= discard;
         if (accept) begin
            fb_wAddr <= {wr_bank, mc_wAddr};
            fb_wData <= mc_wData;
            pix_cnt  <= pix_cnt + 17'd1;
         end
         if (commit) begin
            disp_bank <= ~disp_bank;
            frame_cnt <= frame_cnt + 8'd1;
         end
         if (state == IDLE && state_n == ARM)
            mode_r <= mode_single;
         if (state == ARM && state_n == CAPTURE) begin
            pix_cnt   <= '0;
            stop_pend <= 1'b0;
         end
         if (state == CAPTURE && cmd_stop)
            stop_pend <= 1'b1;
         if (state == CAPTURE && state_n == SKIP)
            skip_cnt <= SKIP_N;
         else if (state == SKIP && rise)
            skip_cnt <= skip_cnt - 8'd1;
      end
   end
endmodule

// File: doc/ov7670_capture_sequencer.md
# ov7670_capture_sequencer

Frame-level capture controller between the OV7670 pixel-write path and the dual-bank frame buffer. It accepts per-pixel writes already assembled by the camera memory controller and gates them by frame: start, stop, single-shot, continuous and decimated capture. It steers each frame into the back bank of a ping-pong buffer. A bank swap to the display happens only after a frame completes with exactly the expected pixel count.

## Interface
- FRAME_PIXELS, 76800: pixels per complete frame (320x240).
- DECIM, 1: in continuous mode, capture 1 frame in every DECIM frames (1..255).
- pclk  in  1  camera pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- v_sync  in  1  camera VSYNC. High means vertical blanking. The falling edge starts a frame; the rising edge ends it.
- mc_we  in  1  pixel write strobe from the memory controller.
- mc_wAddr  in  17  pixel address within a frame.
- mc_wData  in  16  RGB565 pixel.
- cmd_start  in  1  start request; a level is sampled each cycle.
- cmd_stop  in  1  stop request; a level is sampled each cycle.
- mode_single  in  1  sampled when cmd_start is accepted. 1 = capture one frame then go idle; 0 = continuous.
- fb_we  out  1  frame-buffer write enable.
- fb_wAddr  out  18  {wr_bank, pixel address}.
- fb_wData  out  16  pixel data.
- disp_bank  out  1  bank holding the last complete frame; the display reads this bank.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame is committed.
- frame_err  out  1  one-cycle pulse when a frame is discarded because its pixel count was not FRAME_PIXELS.
- frame_cnt  out  8  count of committed frames; wraps 255 -> 0.

## Operation
- Edge detection uses a register v_sync_d, reset to 0.
  - rise = v_sync & ~v_sync_d.
  - fall = ~v_sync & v_sync_d.
- Internal state:
  - wr_bank is always ~disp_bank.
  - pix_cnt is 17 bits.
  - skip_cnt is 8 bits.
  - mode_r latches mode_single.
  - stop_pend is a flag.
- FSM states:
  - IDLE:
    - Goes to ARM when cmd_start=1 and cmd_stop=0; latches mode_r.
    - If cmd_start and cmd_stop are both 1, stop wins and the FSM stays in IDLE.
  - ARM:
    - cmd_stop -> IDLE immediately.
    - fall -> CAPTURE, with pix_cnt cleared to 0 and stop_pend cleared to 0.
    - The FSM enters ARM mid-frame (v_sync low), so it always waits for a full fresh frame.
  - CAPTURE:
    - Each cycle with mc_we=1, mc_wAddr < FRAME_PIXELS and pix_cnt < FRAME_PIXELS, forward the write and increment pix_cnt.
    - Writes that fail either condition are dropped.
    - cmd_stop sets stop_pend. Capture continues to the end of the frame; a stop is never mid-frame.
    - A write on a rise cycle is dropped.
    - On rise, if pix_cnt == FRAME_PIXELS, the frame is committed:
      - toggle disp_bank;
      - pulse frame_done;
      - increment frame_cnt.
    - On rise, otherwise, pulse frame_err and leave disp_bank unchanged.
    - Next state after rise:
      - IDLE if mode_r=1 and the frame was committed, or if stop_pend=1;
      - ARM if mode_r=1 and the frame was discarded (retry);
      - SKIP with skip_cnt=DECIM-1 if continuous and DECIM>1;
      - ARM otherwise.
  - SKIP:
    - Each rise decrements skip_cnt.
    - When skip_cnt reaches 0 -> ARM.
    - cmd_stop -> IDLE immediately.
    - Writes are dropped.
- cmd_start is ignored while busy=1.
- Reset mid-operation forces IDLE and clears all counters, flags and outputs. No frame_done pulse is generated.

## Timing
- The write path is registered: fb_we, fb_wAddr and fb_wData appear 1 cycle after the corresponding mc_* inputs. fb_we is high for exactly one cycle per forwarded write.
- State, disp_bank, frame_done, frame_err and frame_cnt update on the clock edge that samples the rise/fall condition. The new values are visible in the following cycle.
- disp_bank toggles in the same cycle that frame_done is high.
- A write registered in the cycle before rise lands in the old wr_bank. The first write after a swap targets the new wr_bank.
- Reset values:
  - fb_we=0, fb_wAddr=0, fb_wData=0;
  - disp_bank=0, so wr_bank=1;
  - busy=0, frame_done=0, frame_err=0, frame_cnt=0;
  - FSM in IDLE.

## Test plan
Tests 1-4 use FRAME_PIXELS=8.
- Single shot: reset, then cmd_start with mode_single=1, then a v_sync fall, 8 writes at addresses 0..7, and a v_sync rise.
  - fb_wAddr runs 0x20000..0x20007, each 1 cycle after its mc_we.
  - frame_done pulses once, disp_bank goes 0 -> 1, frame_cnt goes 0 -> 1, then busy=0.
- Short and long frames:
  - 7 writes then rise -> frame_err pulse, disp_bank unchanged, state returns to ARM.
  - 10 writes -> only the first 8 are forwarded, then frame_done.
  - A write at address 8 is never forwarded.
- Continuous mode, DECIM=3, 9 frames: frames 1, 4 and 7 are committed; frame_cnt=3; disp_bank alternates 1, 0, 1; fb_we never asserts during skipped frames.
- Mid-frame stop: cmd_stop at write 4 of a continuous capture -> the remaining writes are still forwarded, frame_done pulses at rise, then IDLE.
- Arm latency and simultaneous commands:
  - cmd_start asserted while v_sync is low mid-frame -> no writes until after the next fall.
  - cmd_start and cmd_stop both high in IDLE -> busy stays 0.
- Reset mid-CAPTURE after 3 writes -> all outputs take their reset values the next cycle; no frame_done pulse.
